// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter: master drives the controls, slave is the counter.
interface mod_updown_counter_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] max_val;
   logic             sat_mode;
   logic             clr_flag;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             wrap_pulse;
   logic             ovf_sticky;

   modport master (
      output en, up_dn, load, load_val, max_val, sat_mode, clr_flag,
      input  count, tc, wrap_pulse, ovf_sticky
   );

   modport slave (
      input  en, up_dn, load, load_val, max_val, sat_mode, clr_flag,
      output count, tc, wrap_pulse, ovf_sticky
   );
endinterface

// File: rtl/mod_updown_counter.sv
// Parametrised up/down wrap-or-saturate counter with terminal count, wrap pulse and sticky overflow.
// Optional enable prescaler is built only when COUNTER_PRESCALE_EN is defined.
module mod_updown_counter #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 4
) (
   input  logic                clk,
   input  logic                rst,
   mod_updown_counter_if.slave bus
);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("mod_updown_counter: WIDTH out of range 2..32");
   end
   if (PRESCALE < 2 || PRESCALE > 256) begin : g_bad_prescale
      $error("mod_updown_counter: PRESCALE out of range 2..256");
   end

   logic [WIDTH-1:0] r_count;
   logic             r_wrap_pulse;
   logic             r_ovf_sticky;

   logic             w_tc;
   logic             w_step_req;
   logic             w_pre_hit;
   logic             w_step;
   logic             w_event;
   logic [WIDTH-1:0] w_count_nxt;

   // Saturating or wrapping step; an out-of-range count is treated as already at the terminal.
   function automatic logic [WIDTH-1:0] f_next_count(
      input logic [WIDTH-1:0] cnt,
      input logic [WIDTH-1:0] max,
      input logic             up,
      input logic             sat
   );
      if (up) begin
         if (cnt < max) return cnt + 1'b1;
         else if (sat)  return max;
         else           return '0;
      end else begin
         if (cnt != '0) return cnt - 1'b1;
         else if (sat)  return '0;
         else           return max;
      end
   endfunction

   assign w_tc        = bus.up_dn ? (r_count >= bus.max_val) : (r_count == '0);
   assign w_step_req  = bus.en & ~bus.load;
   assign w_step      = w_step_req & w_pre_hit;
   assign w_event     = w_step & w_tc;
   assign w_count_nxt = f_next_count(r_count, bus.max_val, bus.up_dn, bus.sat_mode);

`ifdef COUNTER_PRESCALE_EN
   localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] r_pre;

   assign w_pre_hit = (r_pre == PRE_LAST);

   always_ff @(posedge clk) begin
      if (rst || bus.load) begin
         r_pre <= '0;
      end else if (bus.en) begin
         if (w_pre_hit) r_pre <= '0;
         else           r_pre <= r_pre + 1'b1;
      end
   end
`else
   assign w_pre_hit = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (bus.load) begin
         r_count <= bus.load_val;
      end else if (w_step) begin
         r_count <= w_count_nxt;
      end
   end

   // Event set dominates a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrap_pulse <= 1'b0;
         r_ovf_sticky <= 1'b0;
      end else begin
         r_wrap_pulse <= w_event;
         if (w_event)           r_ovf_sticky <= 1'b1;
         else if (bus.clr_flag) r_ovf_sticky <= 1'b0;
      end
   end

   assign bus.count      = r_count;
   assign bus.tc         = w_tc;
   assign bus.wrap_pulse = r_wrap_pulse;
   assign bus.ovf_sticky = r_ovf_sticky;

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised successor to the team's fixed 8-bit free-running wrap counter.
- Configurable width, programmable terminal value, up/down direction, parallel load, and wrap or saturate mode.
- Provides a terminal-count indication, a one-cycle wrap event pulse and a sticky overflow flag.
- Used as the general timer/event-counter primitive in datapath and control blocks.

Parameters:
- WIDTH, 8, counter width in bits (legal range 2..32).
- PRESCALE, 4, enable divide ratio (legal range 2..256). Used only when COUNTER_PRESCALE_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per qualified cycle.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- max_val  input  WIDTH  terminal value for up-count; reload value for down-wrap; sampled every cycle.
- sat_mode  input  1  0 = wrap at terminal, 1 = saturate at terminal.
- clr_flag  input  1  clears ovf_sticky.
- count  output  WIDTH  registered counter value.
- tc  output  1  combinational terminal-count indication.
- wrap_pulse  output  1  registered one-cycle event pulse.
- ovf_sticky  output  1  registered sticky overflow/underflow flag.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst). All state updates on the rising clk edge.
- Reset (rst=1 at edge): count=0, wrap_pulse=0, ovf_sticky=0, prescaler=0. Reset overrides every other input.
- Priority at each edge: rst > load > step > hold.
- Load: count <= load_val. Load takes effect even if load_val > max_val. wrap_pulse=0 that cycle. ovf_sticky is unaffected except by clr_flag.
- Step: occurs when en=1 and load=0, qualified by the prescaler if COUNTER_PRESCALE_EN is defined.
- Up step:
  - count < max_val: count+1.
  - count >= max_val and sat_mode=0: count <= 0 (wrap event).
  - count >= max_val and sat_mode=1: count <= max_val (saturate event). This clamps an out-of-range count down to max_val.
- Down step:
  - count > 0: count-1.
  - count == 0 and sat_mode=0: count <= max_val (wrap event).
  - count == 0 and sat_mode=1: count holds 0 (saturate event).
- tc (combinational): up_dn=1 -> (count >= max_val); up_dn=0 -> (count == 0). tc is independent of en. Tests must sample it settled, before the edge.
- Event: a step taken while tc=1.
  - wrap_pulse <= 1 for exactly the cycle after the event edge; otherwise 0.
  - A repeated saturate event gives wrap_pulse=1 on consecutive cycles.
- ovf_sticky:
  - Set by any event; held until clr_flag=1 at an edge.
  - Event and clr_flag in the same cycle: set wins, ovf_sticky=1.
- max_val=0:
  - Up with sat_mode=0: count stays 0, event every step.
  - Down: count stays 0, event every step.
- Arithmetic is unsigned modulo 2^WIDTH. No internal width growth. count never exceeds 2^WIDTH-1.
- Direction or mode may change on any cycle. The new value applies to the step at that same edge.
- Reset asserted mid-count: next cycle count=0 and all flags clear. Any pending prescaler phase is discarded.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler (width ceil(log2(PRESCALE))) increments on each en=1, load=0 cycle.
  - A step occurs only on the cycle the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - load=1 or rst=1 clears the prescaler.
  - en=0 holds the prescaler.
  - tc remains purely a function of count, up_dn and max_val.
- Undefined: no prescaler logic; every en=1, load=0 cycle is a step. PRESCALE is ignored.

Test Plan:
- (WIDTH=8 unless noted.)
- Reset: drive rst=1 with en=1, load=1, load_val=8'h55 -> count=0, wrap_pulse=0, ovf_sticky=0 after the edge.
- Up wrap: max_val=9, sat_mode=0, up_dn=1, en=1 from 0 for 12 cycles -> count 0..9,0,1; tc=1 while count=9; wrap_pulse=1 only the cycle count shows 0 after 9; ovf_sticky=1 thereafter.
- Down saturate: load_val=3 then en=1, up_dn=0, sat_mode=1 -> count 3,2,1,0,0,0; wrap_pulse=1 on each cycle following a step taken at 0; clr_flag pulsed during an event -> ovf_sticky stays 1.
- Out-of-range load: max_val=10, load_val=200, up_dn=1, sat_mode=1, en=1 -> count 200 then 10 then holds 10, tc=1 throughout; repeat with sat_mode=0 -> 200 then 0.
- Priority: load=1 and en=1 with count=max_val -> count=load_val, wrap_pulse=0; then clr_flag=1 with no event -> ovf_sticky=0.
- Prescale (COUNTER_PRESCALE_EN, PRESCALE=4): en=1 continuously, max_val=255 -> count increments once every 4 cycles; load mid-period restarts the 4-cycle phase; en low for 2 cycles stretches the period to 6.
